// File: rtl/vc_sched_pkg.sv
// Shared defaults and state encoding for the virtual-channel output scheduler.
package vc_sched_pkg;

  localparam int DEF_NUM_VC       = 4;
  localparam int DEF_LOG_NUM_VC   = 2;
  localparam int DEF_CREDIT_WIDTH = 4;
  localparam int DEF_MAX_CREDIT   = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin arbiter: first request at or above i_ptr wins,
// searching upward and wrapping, via a doubled request vector.
module rr_arbiter_comb #(
  parameter int N    = 4,
  parameter int LOGN = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [LOGN-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [LOGN-1:0] o_grant_idx,
  output logic            o_any_grant
);

  logic [2*N-1:0] w_rotated;

  always_comb begin
    w_rotated   = {i_req, i_req} >> i_ptr;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!o_any_grant && w_rotated[j]) begin
        o_any_grant = 1'b1;
        o_grant_idx = LOGN'((int'(i_ptr) + j) % N);
        o_grant     = N'(1) << ((int'(i_ptr) + j) % N);
      end
    end
  end

endmodule

// File: rtl/vc_fifo_scheduler.sv
// Wormhole round-robin output scheduler over a bank of VC FIFOs with
// per-VC downstream credit tracking.
module vc_fifo_scheduler
  import vc_sched_pkg::*;
#(
  parameter int NUM_VC       = DEF_NUM_VC,
  parameter int LOG_NUM_VC   = DEF_LOG_NUM_VC,
  parameter int CREDIT_WIDTH = DEF_CREDIT_WIDTH,
  parameter int MAX_CREDIT   = DEF_MAX_CREDIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_VC-1:0]     fifo_empty,
  input  logic [NUM_VC-1:0]     fifo_tail,
  input  logic                  out_ready,
  input  logic [NUM_VC-1:0]     credit_in,
  output logic [NUM_VC-1:0]     fifo_read,
  output logic                  out_valid,
  output logic [LOG_NUM_VC-1:0] out_vc,
  output logic                  out_tail,
  output logic                  locked,
  output logic                  credit_err
);

  localparam logic [CREDIT_WIDTH-1:0] MAX_CNT  = CREDIT_WIDTH'(MAX_CREDIT);
  localparam logic [CREDIT_WIDTH-1:0] ONE_CNT  = CREDIT_WIDTH'(1);
  localparam logic [LOG_NUM_VC-1:0]   LAST_VC  = LOG_NUM_VC'(NUM_VC - 1);

  sched_state_e          r_state, w_state_nxt;
  logic [LOG_NUM_VC-1:0] r_lock_vc, w_lock_vc_nxt;
  logic [LOG_NUM_VC-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic                  r_credit_err;

  logic [NUM_VC-1:0]     w_elig, w_cand, w_grant, w_err_hit;
  logic [LOG_NUM_VC-1:0] w_grant_idx;
  logic                  w_any, w_xfer;

  // Simultaneous pop and return cancel; a return at full credit is an error.
  for (genvar i = 0; i < NUM_VC; i++) begin : g_credit
    logic [CREDIT_WIDTH-1:0] r_credit;
    logic                    w_at_max;

    assign w_at_max     = (r_credit == MAX_CNT);
    assign w_elig[i]    = ~fifo_empty[i] & (r_credit != '0);
    assign w_err_hit[i] = credit_in[i] & ~fifo_read[i] & w_at_max;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_credit <= MAX_CNT;
      end else if (fifo_read[i] & ~credit_in[i]) begin
        r_credit <= r_credit - ONE_CNT;
      end else if (credit_in[i] & ~fifo_read[i] & ~w_at_max) begin
        r_credit <= r_credit + ONE_CNT;
      end
    end
  end

  assign w_cand = (r_state == LOCKED) ? (w_elig & (NUM_VC'(1) << r_lock_vc)) : w_elig;

  rr_arbiter_comb #(
    .N    (NUM_VC),
    .LOGN (LOG_NUM_VC)
  ) u_arb (
    .i_req       (w_cand),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_grant (w_any)
  );

  // Gating with reset keeps every output low while reset is held.
  assign w_xfer = reset & enable & out_ready & w_any;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_lock_vc    <= '0;
      r_rr_ptr     <= '0;
      r_credit_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lock_vc    <= w_lock_vc_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_credit_err <= r_credit_err | (|w_err_hit);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lock_vc_nxt = r_lock_vc;
    w_rr_ptr_nxt  = r_rr_ptr;
    fifo_read     = '0;
    out_valid     = 1'b0;
    out_vc        = '0;
    out_tail      = 1'b0;
    if (w_xfer) begin
      fifo_read = w_grant;
      out_valid = 1'b1;
      out_vc    = w_grant_idx;
      out_tail  = fifo_tail[w_grant_idx];
      // The round-robin pointer only advances once a whole packet has gone.
      if (fifo_tail[w_grant_idx]) begin
        w_state_nxt  = IDLE;
        w_rr_ptr_nxt = (w_grant_idx == LAST_VC) ? '0 : w_grant_idx + LOG_NUM_VC'(1);
      end else begin
        w_state_nxt   = LOCKED;
        w_lock_vc_nxt = w_grant_idx;
      end
    end
  end

  assign locked     = (r_state == LOCKED);
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_vc_fifo_scheduler.sv
// Self-checking bench for vc_fifo_scheduler: FIFO bank and downstream credits
// are modelled with counters and circular buffers of head-flit tail bits.
module tb_vc_fifo_scheduler;

  localparam int N    = 4;
  localparam int L    = 2;
  localparam int MAXC = 8;
  localparam int W    = N + L + 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] fifo_empty = '1;
  logic [N-1:0] fifo_tail = '0;
  logic [N-1:0] credit_in = '0;
  logic [N-1:0] fifo_read;
  logic         out_valid, out_tail, locked, credit_err;
  logic [L-1:0] out_vc;

  always #5 clock = ~clock;

  vc_fifo_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_tail  (fifo_tail),
    .out_ready  (out_ready),
    .credit_in  (credit_in),
    .fifo_read  (fifo_read),
    .out_valid  (out_valid),
    .out_vc     (out_vc),
    .out_tail   (out_tail),
    .locked     (locked),
    .credit_err (credit_err)
  );

  bit   qbuf [N][64];
  int   qrd [N];
  int   qwr [N];
  int   m_credit [N];
  bit   m_locked;
  int   m_lock_vc;
  int   m_ptr;
  bit   m_err;
  bit   e_valid, e_tail;
  int   e_vc;
  logic [W-1:0] e_vec, o_vec;
  int   errors = 0;
  int   checks = 0;

  function automatic int qsize(int i);
    return qwr[i] - qrd[i];
  endfunction

  task automatic push(int i, bit t);
    qbuf[i][qwr[i] % 64] = t;
    qwr[i]++;
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (qsize(i) == 0);
      fifo_tail[i]  = (qsize(i) > 0) ? qbuf[i][qrd[i] % 64] : 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_credit[i] = MAXC;
    m_locked  = 1'b0;
    m_lock_vc = 0;
    m_ptr     = 0;
    m_err     = 1'b0;
  endtask

  // Reference decision: scan VCs starting at the pointer, a packet in flight
  // restricts the choice to its own VC.
  task automatic evaluate();
    logic [N-1:0] e_read;
    @(negedge clock);
    e_valid = 1'b0;
    e_tail  = 1'b0;
    e_vc    = 0;
    e_read  = '0;
    if (reset && enable && out_ready) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (!e_valid && qsize(i) > 0 && m_credit[i] > 0 && (!m_locked || i == m_lock_vc)) begin
          e_valid = 1'b1;
          e_vc    = i;
          e_tail  = qbuf[i][qrd[i] % 64];
        end
      end
    end
    if (e_valid) e_read[e_vc] = 1'b1;
    e_vec = {e_read, e_valid, L'(e_vc), e_tail, m_locked, m_err};
    o_vec = {fifo_read, out_valid, out_vc, out_tail, locked, credit_err};
  endtask

  task automatic advance();
    @(posedge clock);
    if (reset) begin
      if (e_valid) begin
        m_credit[e_vc]--;
        qrd[e_vc]++;
        if (e_tail) begin
          m_locked = 1'b0;
          m_ptr    = (e_vc + 1) % N;
        end else begin
          m_locked  = 1'b1;
          m_lock_vc = e_vc;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (credit_in[i]) begin
          if (m_credit[i] == MAXC) m_err = 1'b1;
          else m_credit[i]++;
        end
      end
    end
    #1;
    credit_in = '0;
    drive_fifo();
  endtask

  task automatic test_reset();
    model_reset();
    enable    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) push(i, 1'b1);
    drive_fifo();
    evaluate();
    checks++;
    if (o_vec !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b want=%b", o_vec, {W{1'b0}});
    end
    checks++;
    if (o_vec !== e_vec) begin
      errors++;
      $display("[TB] FAIL reset_model got=%b want=%b", o_vec, e_vec);
    end
    advance();
    reset = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < N; k++) begin
      evaluate();
      checks++;
      if (o_vec !== e_vec) begin
        errors++;
        $display("[TB] FAIL rr_model k=%0d got=%b want=%b", k, o_vec, e_vec);
      end
      checks++;
      if (out_valid !== 1'b1 || out_vc !== L'(k) || out_tail !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rr_order k=%0d got valid=%b vc=%0d tail=%b want valid=1 vc=%0d tail=1",
                 k, out_valid, out_vc, out_tail, k);
      end
      advance();
    end
    evaluate();
    checks++;
    if (out_valid !== 1'b0 || o_vec !== e_vec) begin
      errors++;
      $display("[TB] FAIL rr_drained got=%b want=%b", o_vec, e_vec);
    end
    advance();
  endtask

  task automatic test_wormhole();
    int exp_vc [4] = '{1, 1, 1, 2};
    bit exp_lk [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    push(0, 1'b1);
    drive_fifo();
    evaluate();
    checks++;
    if (o_vec !== e_vec) begin
      errors++;
      $display("[TB] FAIL worm_setup got=%b want=%b", o_vec, e_vec);
    end
    advance();
    push(1, 1'b0); push(1, 1'b0); push(1, 1'b1); push(2, 1'b1);
    drive_fifo();
    for (int k = 0; k < 4; k++) begin
      evaluate();
      checks++;
      if (o_vec !== e_vec) begin
        errors++;
        $display("[TB] FAIL worm_model k=%0d got=%b want=%b", k, o_vec, e_vec);
      end
      checks++;
      if (out_valid !== 1'b1 || out_vc !== L'(exp_vc[k]) || locked !== exp_lk[k]) begin
        errors++;
        $display("[TB] FAIL worm_seq k=%0d got vc=%0d locked=%b want vc=%0d locked=%b",
                 k, out_vc, locked, exp_vc[k], exp_lk[k]);
      end
      advance();
    end
    push(0, 1'b1); push(3, 1'b1);
    drive_fifo();
    evaluate();
    checks++;
    if (out_valid !== 1'b1 || out_vc !== L'(3)) begin
      errors++;
      $display("[TB] FAIL worm_ptr got valid=%b vc=%0d want valid=1 vc=3", out_valid, out_vc);
    end
    advance();
    evaluate();
    checks++;
    if (o_vec !== e_vec) begin
      errors++;
      $display("[TB] FAIL worm_after got=%b want=%b", o_vec, e_vec);
    end
    advance();
  endtask

  task automatic test_lock_stall();
    push(1, 1'b0);
    drive_fifo();
    evaluate();
    checks++;
    if (o_vec !== e_vec) begin
      errors++;
      $display("[TB] FAIL stall_head got=%b want=%b", o_vec, e_vec);
    end
    advance();
    push(0, 1'b1);
    drive_fifo();
    for (int k = 0; k < 2; k++) begin
      evaluate();
      checks++;
      if (out_valid !== 1'b0 || fifo_read !== '0 || locked !== 1'b1 || o_vec !== e_vec) begin
        errors++;
        $display("[TB] FAIL stall_hold k=%0d got=%b want=%b", k, o_vec, e_vec);
      end
      advance();
    end
    push(1, 1'b1);
    drive_fifo();
    evaluate();
    checks++;
    if (out_valid !== 1'b1 || out_vc !== L'(1) || out_tail !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_resume got valid=%b vc=%0d tail=%b want valid=1 vc=1 tail=1",
               out_valid, out_vc, out_tail);
    end
    advance();
    evaluate();
    checks++;
    if (out_valid !== 1'b1 || out_vc !== L'(0) || o_vec !== e_vec) begin
      errors++;
      $display("[TB] FAIL stall_release got=%b want=%b", o_vec, e_vec);
    end
    advance();
  endtask

  task automatic test_credit_drain();
    for (int it = 0; it < MAXC + 2; it++) begin
      for (int i = 0; i < N; i++) credit_in[i] = (m_credit[i] < MAXC);
      if (credit_in == '0) break;
      evaluate();
      checks++;
      if (o_vec !== e_vec) begin
        errors++;
        $display("[TB] FAIL refill it=%0d got=%b want=%b", it, o_vec, e_vec);
      end
      advance();
    end
    for (int k = 0; k <= MAXC; k++) push(0, 1'b1);
    drive_fifo();
    for (int k = 0; k < MAXC; k++) begin
      evaluate();
      checks++;
      if (out_valid !== 1'b1 || out_vc !== L'(0) || o_vec !== e_vec) begin
        errors++;
        $display("[TB] FAIL drain k=%0d got=%b want=%b", k, o_vec, e_vec);
      end
      advance();
    end
    evaluate();
    checks++;
    if (fifo_read[0] !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_empty got read=%b valid=%b want read=0 valid=0", fifo_read[0], out_valid);
    end
    advance();
    credit_in[0] = 1'b1;
    evaluate();
    checks++;
    if (out_valid !== 1'b0 || o_vec !== e_vec) begin
      errors++;
      $display("[TB] FAIL drain_return got=%b want=%b", o_vec, e_vec);
    end
    advance();
    evaluate();
    checks++;
    if (out_valid !== 1'b1 || out_vc !== L'(0) || fifo_read[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drain_regrant got valid=%b vc=%0d want valid=1 vc=0", out_valid, out_vc);
    end
    advance();
  endtask

  task automatic test_credit_err();
    credit_in[3] = 1'b1;
    evaluate();
    checks++;
    if (o_vec !== e_vec) begin
      errors++;
      $display("[TB] FAIL err_pulse got=%b want=%b", o_vec, e_vec);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      evaluate();
      checks++;
      if (credit_err !== 1'b1) begin
        errors++;
        $display("[TB] FAIL err_sticky k=%0d got=%b want=1", k, credit_err);
      end
      advance();
    end
    for (int k = 0; k < 3; k++) push(2, 1'b1);
    drive_fifo();
    for (int k = 0; k < 3; k++) begin
      evaluate();
      checks++;
      if (o_vec !== e_vec) begin
        errors++;
        $display("[TB] FAIL err_use k=%0d got=%b want=%b", k, o_vec, e_vec);
      end
      advance();
    end
    push(2, 1'b1);
    drive_fifo();
    credit_in[2] = 1'b1;
    evaluate();
    checks++;
    if (out_valid !== 1'b1 || out_vc !== L'(2) || o_vec !== e_vec) begin
      errors++;
      $display("[TB] FAIL err_both got=%b want=%b", o_vec, e_vec);
    end
    advance();
    for (int k = 0; k < 6; k++) push(2, 1'b1);
    drive_fifo();
    for (int k = 0; k < 6; k++) begin
      evaluate();
      checks++;
      if (o_vec !== e_vec || out_valid !== (k < 5)) begin
        errors++;
        $display("[TB] FAIL err_count k=%0d got=%b want=%b", k, o_vec, e_vec);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    for (int i = 0; i < N; i++) qrd[i] = qwr[i];
    drive_fifo();
    model_reset();
    advance();
    reset = 1'b1;
    push(1, 1'b1); push(2, 1'b0); push(2, 1'b0); push(2, 1'b1);
    drive_fifo();
    for (int k = 0; k < 2; k++) begin
      evaluate();
      checks++;
      if (out_valid !== 1'b1 || out_vc !== L'(k + 1) || o_vec !== e_vec) begin
        errors++;
        $display("[TB] FAIL mid_setup k=%0d got=%b want=%b", k, o_vec, e_vec);
      end
      advance();
    end
    evaluate();
    checks++;
    if (locked !== 1'b1 || o_vec !== e_vec) begin
      errors++;
      $display("[TB] FAIL mid_locked got=%b want=%b", o_vec, e_vec);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || fifo_read !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_async got locked=%b read=%b valid=%b want all 0", locked, fifo_read, out_valid);
    end
    model_reset();
    e_valid = 1'b0;
    advance();
    reset = 1'b1;
    push(0, 1'b1);
    drive_fifo();
    evaluate();
    checks++;
    if (out_valid !== 1'b1 || out_vc !== L'(0)) begin
      errors++;
      $display("[TB] FAIL mid_restart got valid=%b vc=%0d want valid=1 vc=0", out_valid, out_vc);
    end
    advance();
    for (int k = 0; k <= MAXC; k++) push(1, 1'b1);
    drive_fifo();
    for (int k = 0; k < 14; k++) begin
      evaluate();
      checks++;
      if (o_vec !== e_vec) begin
        errors++;
        $display("[TB] FAIL mid_credit k=%0d got=%b want=%b", k, o_vec, e_vec);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (qsize(i) < 6 && $urandom_range(0, 2) == 0) push(i, 1'($urandom_range(0, 1)));
        credit_in[i] = (m_credit[i] < MAXC && $urandom_range(0, 2) == 0) || ($urandom_range(0, 63) == 0);
      end
      enable    = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive_fifo();
      evaluate();
      checks++;
      if (o_vec !== e_vec) begin
        errors++;
        $display("[TB] FAIL random c=%0d en=%b rdy=%b got=%b want=%b", c, enable, out_ready, o_vec, e_vec);
      end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      qrd[i] = 0;
      qwr[i] = 0;
    end
    e_valid = 1'b0;
    test_reset();
    test_round_robin();
    test_wormhole();
    test_lock_stall();
    test_credit_drain();
    test_credit_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_fifo_scheduler.md
Name: vc_fifo_scheduler

Overview:
- Output scheduler for a bank of NUM_VC virtual-channel FIFOs. Each FIFO is an LFSR-addressed RAM FIFO with an output register, so the head flit is always valid on its data output when the FIFO is not empty.
- Each cycle the block picks at most one eligible VC by round-robin, pops it, and tags the outgoing flit with its VC.
- Arbitration is wormhole style: a VC holds the output from head flit to tail flit.
- A VC is eligible only if it has downstream credit. The block keeps a per-VC credit counter that is replenished by credit-return pulses.

Parameters:
- NUM_VC, 4, number of VC FIFOs arbitrated.
- LOG_NUM_VC, 2, width of the VC index; must equal clog2(NUM_VC).
- CREDIT_WIDTH, 4, width of each credit counter.
- MAX_CREDIT, 8, downstream buffer depth per VC; must be at most 2^CREDIT_WIDTH-1.

Ports:
- clock  in  1  single clock; all flops on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- enable  in  1  global enable; when 0, no pops and no state change except credit returns.
- fifo_empty  in  NUM_VC  empty flag of each VC FIFO.
- fifo_tail  in  NUM_VC  head flit of VC i is the last flit of its packet.
- out_ready  in  1  downstream can accept a flit this cycle.
- credit_in  in  NUM_VC  one-cycle credit-return pulse per VC.
- fifo_read  out  NUM_VC  one-hot pop strobe, driven to the FIFO read input.
- out_valid  out  1  a flit is transferred this cycle.
- out_vc  out  LOG_NUM_VC  VC index of the transferred flit; 0 when out_valid=0.
- out_tail  out  1  the transferred flit is a tail.
- locked  out  1  a multi-flit packet is in progress.
- credit_err  out  1  sticky flag: a credit returned while the counter was at MAX_CREDIT.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, lock_vc=0, rr_ptr=0.
  - every credit counter = MAX_CREDIT, credit_err=0.
  - every output is 0 while reset is held.
  - Reset mid-packet discards the lock. No partial-packet recovery.
- Eligibility: elig[i] = ~fifo_empty[i] & (credit[i] != 0).
- States:
  - IDLE: candidates = elig. Grant the first set bit searching from rr_ptr upward, wrapping modulo NUM_VC.
  - LOCKED: candidates = elig & onehot(lock_vc). If the locked VC is empty or has zero credit, the output stalls (out_valid=0). No other VC may be granted.
- Transfer condition: enable & out_ready & (candidate set nonzero).
- Transfer outputs: combinational in the transfer cycle (zero latency), because FIFO data is already registered.
  - fifo_read[g]=1 and out_valid=1.
  - out_vc=g, out_tail=fifo_tail[g].
- Transitions, updated on the clock edge after a transfer:
  - IDLE, non-tail transfer -> LOCKED with lock_vc=g.
  - IDLE, tail transfer (single-flit packet) -> stay IDLE.
  - LOCKED, tail transfer -> IDLE.
  - rr_ptr = (g+1) mod NUM_VC only on a tail transfer. It is unchanged otherwise, including on non-tail transfers.
- Credits, per VC:
  - decrement on fifo_read[i]; increment on credit_in[i].
  - both in the same cycle: unchanged.
  - increment with the counter at MAX_CREDIT: counter unchanged, credit_err set. credit_err clears only on reset.
  - a decrement at 0 cannot occur, because the VC is then not eligible.
- Credit returns are processed even when enable=0. When enable=0, state, rr_ptr and lock_vc hold, and all outputs except locked and credit_err are 0.
- locked = (state==LOCKED), driven from the registered state.
- fifo_tail is ignored for VCs that are not granted.

Decomposition:
- Shared package vc_sched_pkg: NUM_VC, LOG_NUM_VC, CREDIT_WIDTH and MAX_CREDIT defaults; state encoding IDLE=1'b0, LOCKED=1'b1.
- One sub-module, rr_arbiter_comb: purely combinational.
  - inputs: request vector, rr_ptr.
  - outputs: one-hot grant, binary grant index, any_grant.
  - implemented as a doubled-vector priority search.
- Credit counters are generated inline with a generate loop.

Test Plan:
1. Reset release, VC0..3 each hold one tail flit, out_ready=1 -> grants 0,1,2,3 on consecutive cycles; out_tail=1 each time; credits become 7 each.
2. VC1 has a 3-flit packet (tail on flit 3) and VC2 has 1 flit; rr_ptr=1 -> out_vc=1 for 3 cycles with locked=1 on cycles 2-3, then out_vc=2; rr_ptr ends at 3.
3. Locked on VC1 and VC1 goes empty for 2 cycles while VC0 is nonempty -> out_valid=0 for 2 cycles with VC0 not granted; VC1 resumes when it refills.
4. Drain VC0 credit to 0 (8 flits, no returns) -> VC0 not granted and fifo_read[0]=0; one credit_in[0] pulse -> VC0 granted the next cycle.
5. credit_in[3] with credit[3]=8 -> counter stays 8, credit_err=1 and stays 1; simultaneous fifo_read[2] and credit_in[2] at 5 -> stays 5.
6. Pull reset low mid-packet (locked=1) -> locked=0 and fifo_read=0 immediately; after release, credits are 8 and arbitration starts at VC0.
